imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader that assembles big-endian words into instruction memory.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_ldr_i,
    input  logic        byte_valid_ldr_i,
    input  logic [7:0]  byte_data_ldr_i,
    output logic        byte_ready_ldr_o,
    output logic        wr_en_imem_ldr_o,
    output logic [31:0] addr_imem_ldr_o,
    output logic [31:0] wr_instr_imem_ldr_o,
    output logic        cpu_hold_ldr_o,
    output logic        done_ldr_o,
    output logic        err_ldr_o
);
    localparam int WCW = $clog2(MAX_WORDS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef IMEM_LOADER_CKSUM_EN
        S_CKSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t           r_state;
    logic [7:0]       r_len_hi;
    logic [WCW-1:0]   r_len;
    logic [WCW-1:0]   r_wcnt;
    logic [1:0]       r_bcnt;
    logic [23:0]      r_word;
    logic             r_wr_en;
    logic [31:0]      r_addr;
    logic [31:0]      r_data;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]       r_cksum;
`endif

    logic             w_acc;
    logic [15:0]      w_len;
    logic [WCW-1:0]   w_wcnt_nx;
    logic             w_last;
    state_t           w_fin_state;

    assign byte_ready_ldr_o    = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) || (r_state == S_DATA)
`ifdef IMEM_LOADER_CKSUM_EN
                                 || (r_state == S_CKSUM)
`endif
                                 ;
    assign w_acc               = byte_valid_ldr_i && byte_ready_ldr_o;
    assign w_len               = {r_len_hi, byte_data_ldr_i};
    assign w_wcnt_nx           = r_wcnt + 1'b1;
    assign w_last              = (w_wcnt_nx == r_len);
`ifdef IMEM_LOADER_CKSUM_EN
    assign w_fin_state         = S_CKSUM;
`else
    assign w_fin_state         = S_DONE;
`endif
    assign wr_en_imem_ldr_o    = r_wr_en;
    assign addr_imem_ldr_o     = r_addr;
    assign wr_instr_imem_ldr_o = r_data;
    assign cpu_hold_ldr_o      = (r_state != S_DONE);
    assign done_ldr_o          = (r_state == S_DONE);
    assign err_ldr_o           = (r_state == S_ERR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_len_hi <= '0;
            r_len    <= '0;
            r_wcnt   <= '0;
            r_bcnt   <= '0;
            r_word   <= '0;
            r_wr_en  <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            r_cksum  <= '0;
`endif
        end else begin
            r_wr_en <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            if (w_acc && r_state != S_CKSUM)
                r_cksum <= r_cksum ^ byte_data_ldr_i;
`endif
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_ldr_i) begin
                        r_state <= S_LEN_HI;
                        r_wcnt  <= '0;
                        r_bcnt  <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
                        r_cksum <= '0;
`endif
                    end
                end
                S_LEN_HI: begin
                    if (w_acc) begin
                        r_len_hi <= byte_data_ldr_i;
                        r_state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_acc) begin
                        r_len   <= w_len[WCW-1:0];
                        r_state <= (w_len > 16'(MAX_WORDS)) ? S_ERR :
                                   (w_len == 16'd0)         ? w_fin_state : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_bcnt <= r_bcnt + 2'd1;
                        r_word <= {r_word[15:0], byte_data_ldr_i};
                        // Fourth byte completes the word; the strobe fires next cycle while bytes keep flowing
                        if (r_bcnt == 2'd3) begin
                            r_wr_en <= 1'b1;
                            r_addr  <= {{(30 - WCW){1'b0}}, r_wcnt, 2'b00};
                            r_data  <= {r_word, byte_data_ldr_i};
                            r_wcnt  <= w_wcnt_nx;
                            if (w_last)
                                r_state <= w_fin_state;
                        end
                    end
                end
`ifdef IMEM_LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (w_acc)
                        r_state <= (byte_data_ldr_i == r_cksum) ? S_DONE : S_ERR;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader (covers both IMEM_LOADER_CKSUM_EN builds).
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_ldr_i;
    logic        byte_valid_ldr_i;
    logic [7:0]  byte_data_ldr_i;
    logic        byte_ready_ldr_o;
    logic        wr_en_imem_ldr_o;
    logic [31:0] addr_imem_ldr_o;
    logic [31:0] wr_instr_imem_ldr_o;
    logic        cpu_hold_ldr_o;
    logic        done_ldr_o;
    logic        err_ldr_o;

    int n_chk = 0;
    int n_bad = 0;
    int n_wr = 0;
    int stalls = 0;
    logic [63:0] sbq[$];

    imem_loader #(.MAX_WORDS(256)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start_ldr_i         (start_ldr_i),
        .byte_valid_ldr_i    (byte_valid_ldr_i),
        .byte_data_ldr_i     (byte_data_ldr_i),
        .byte_ready_ldr_o    (byte_ready_ldr_o),
        .wr_en_imem_ldr_o    (wr_en_imem_ldr_o),
        .addr_imem_ldr_o     (addr_imem_ldr_o),
        .wr_instr_imem_ldr_o (wr_instr_imem_ldr_o),
        .cpu_hold_ldr_o      (cpu_hold_ldr_o),
        .done_ldr_o          (done_ldr_o),
        .err_ldr_o           (err_ldr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en_imem_ldr_o) begin
            logic [63:0] e;
            n_wr++;
            check("sb_pending", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("wr_addr", 64'(addr_imem_ldr_o), 64'(e[63:32]));
                check("wr_data", 64'(wr_instr_imem_ldr_o), 64'(e[31:0]));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(byte_ready_ldr_o), 64'd0);
        check({tag, "_wr"},    64'(wr_en_imem_ldr_o), 64'd0);
        check({tag, "_addr"},  64'(addr_imem_ldr_o), 64'd0);
        check({tag, "_data"},  64'(wr_instr_imem_ldr_o), 64'd0);
        check({tag, "_hold"},  64'(cpu_hold_ldr_o), 64'd1);
        check({tag, "_done"},  64'(done_ldr_o), 64'd0);
        check({tag, "_err"},   64'(err_ldr_o), 64'd0);
    endtask

    task automatic do_start();
        start_ldr_i = 1'b1;
        @(posedge clk); #1;
        start_ldr_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        byte_valid_ldr_i = 1'b1;
        byte_data_ldr_i  = b;
        for (int k = 0; k < 50; k++) begin
            if (byte_ready_ldr_o) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        if (!ok) check("send_timeout", 64'(ok), 64'd1);
    endtask

    task automatic send_seq(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i]);
        byte_valid_ldr_i = 1'b0;
        byte_data_ldr_i  = 8'hxx;
    endtask

    // Build a session stream, pushing each expected write; bad_ck corrupts the checksum byte
    task automatic build(input int n, input logic [31:0] w[4], input bit bad_ck, output logic [7:0] bs[$]);
        logic [7:0] ck;
        bs = {};
        bs.push_back(8'(n >> 8));
        bs.push_back(8'(n));
        for (int i = 0; i < n && i < 4; i++) begin
            for (int k = 0; k < 4; k++) bs.push_back(8'(w[i] >> (24 - 8 * k)));
            sbq.push_back({32'(4 * i), w[i]});
        end
        ck = 8'h00;
        foreach (bs[i]) ck ^= bs[i];
`ifdef IMEM_LOADER_CKSUM_EN
        bs.push_back(bad_ck ? ck ^ 8'h5A : ck);
`else
        if (bad_ck) ck = 8'h00;
`endif
    endtask

    task automatic wait_end(input string tag);
        int k;
        for (k = 0; k < 50 && !(done_ldr_o || err_ldr_o); k++) begin
            @(posedge clk); #1;
        end
        check({tag, "_end_reached"}, 64'(done_ldr_o || err_ldr_o), 64'd1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  bs[$];
        logic [31:0] w[4];
        int          wr0;
        reset = 1'b0;
        start_ldr_i = 1'b0;
        byte_valid_ldr_i = 1'b0;
        byte_data_ldr_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", 64'(byte_ready_ldr_o), 64'd0);

        // single word load
        do_start();
        check("lenhi_ready", 64'(byte_ready_ldr_o), 64'd1);
        w = '{32'h20080005, 0, 0, 0};
        build(1, w, 0, bs);
        send_seq(bs);
        wait_end("load");
        check("load_done", 64'(done_ldr_o), 64'd1);
        check("load_hold", 64'(cpu_hold_ldr_o), 64'd0);
        check("load_ready", 64'(byte_ready_ldr_o), 64'd0);
        check("load_addr_hold", 64'(addr_imem_ldr_o), 64'h0);
        check("load_data_hold", 64'(wr_instr_imem_ldr_o), 64'h20080005);
        check("load_wr_cnt", 64'(n_wr), 64'd1);
        check("load_sb_empty", 64'(sbq.size()), 64'd0);

        // back-to-back three words, valid held high
        @(posedge clk); #1;
        do_start();
        w = '{32'hDEADBEEF, 32'h01234567, 32'hA5C3F00F, 0};
        stalls = 0;
        build(3, w, 0, bs);
        send_seq(bs);
        check("b2b_stalls", 64'(stalls), 64'd0);
        wait_end("b2b");
        check("b2b_done", 64'(done_ldr_o), 64'd1);
        check("b2b_wr_cnt", 64'(n_wr), 64'd4);
        check("b2b_addr_hold", 64'(addr_imem_ldr_o), 64'h8);
        check("b2b_sb_empty", 64'(sbq.size()), 64'd0);

        // oversize length is rejected
        @(posedge clk); #1;
        do_start();
        wr0 = n_wr;
        bs = '{8'h01, 8'h01};
        send_seq(bs);
        wait_end("over");
        check("over_err", 64'(err_ldr_o), 64'd1);
        check("over_hold", 64'(cpu_hold_ldr_o), 64'd1);
        check("over_no_wr", 64'(n_wr - wr0), 64'd0);
        do_start();
        check("over_restart_ready", 64'(byte_ready_ldr_o), 64'd1);
        check("over_restart_err", 64'(err_ldr_o), 64'd0);

        // zero length, also exercises a restart that is already in LEN_HI
        bs = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CKSUM_EN
        bs.push_back(8'h00);
`endif
        send_seq(bs);
        wait_end("zero");
        check("zero_done", 64'(done_ldr_o), 64'd1);
        check("zero_no_wr", 64'(n_wr - wr0), 64'd0);

        // exact MAX_WORDS boundary header is accepted (then aborted by reset)
        @(posedge clk); #1;
        do_start();
        bs = '{8'h01, 8'h00, 8'h11, 8'h22};
        send_seq(bs);
        check("max_len_ready", 64'(byte_ready_ldr_o), 64'd1);
        check("max_len_err", 64'(err_ldr_o), 64'd0);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_wr", 64'(n_wr - wr0), 64'd0);
        check("abort_idle_ready", 64'(byte_ready_ldr_o), 64'd0);
        check("abort_idle_hold", 64'(cpu_hold_ldr_o), 64'd1);

        // bad checksum: word still written, result depends on build
        do_start();
        w = '{32'hCAFEF00D, 0, 0, 0};
        build(1, w, 1, bs);
        send_seq(bs);
        wait_end("ck");
        check("ck_wr_cnt", 64'(n_wr - wr0), 64'd1);
        check("ck_data", 64'(wr_instr_imem_ldr_o), 64'hCAFEF00D);
`ifdef IMEM_LOADER_CKSUM_EN
        check("ck_err", 64'(err_ldr_o), 64'd1);
        check("ck_hold", 64'(cpu_hold_ldr_o), 64'd1);
`else
        check("ck_done", 64'(done_ldr_o), 64'd1);
        check("ck_hold", 64'(cpu_hold_ldr_o), 64'd0);
`endif
        check("ck_sb_empty", 64'(sbq.size()), 64'd0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
